edge_nms_threshold: RTL

Downstream consumer of the Sobel gradient stream: accepts per-pixel gradient magnitude and quantised direction in raster order, buffers two lines to form a 3x3 magnitude window, and applies non-maximum suppression along the gradient direction followed by thresholding. It emits a thinned edge map for interior pixels and is the next stage of the edge detection pipeline, after the gradient stage and before frame output.

---
 rtl/edge_nms_threshold.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/edge_nms_threshold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : edge_nms_threshold                                         |
// | Description : Non-maximum suppression and thresholding of a raster       |
// |               gradient stream. Two magnitude line buffers and one        |
// |               direction line buffer build a 3x3 window centred on        |
// |               (row-1,col-1) as pixel (row,col) arrives. The centre is    |
// |               kept when it is not smaller than both neighbours along its |
// |               gradient direction. A kept centre is then classified       |
// |               against the thresholds. Only interior centres produce      |
// |               output.                                                    |
// | Option      : EDGE_HYST_EN - when defined, a kept centre in              |
// |               [th_low, th_high) is reported as weak (128). When it is    |
// |               undefined, th_low is ignored and the output is 0 or 255.   |
// | Ports       : clk, rst_n (async, active low)                             |
// |               in_valid, in_sof, grad_mag[7:0], grad_dir[7:0] - input     |
// |               th_high[7:0], th_low[7:0] - thresholds, frame-stable       |
// |               out_valid, edge_pixel[7:0], out_last - result stream       |
// | Latency     : pixel sampled at edge t -> stage 1 at edge t,              |
// |               result registered at edge t+1.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module edge_nms_threshold #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] grad_mag,
    input  logic [7:0] grad_dir,
    input  logic [7:0] th_high,
    input  logic [7:0] th_low,
    output logic       out_valid,
    output logic [7:0] edge_pixel,
    output logic       out_last
);

    localparam int c_COL_W = $clog2(IMG_WIDTH);
    localparam int c_ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    // Direction codes are degrees carried on 8 bits. 270 and 315 do not fit,
    // so they arrive as their low 8 bits (270 -> 14, 315 -> 59).
    localparam logic [7:0] c_DIR_45  = 8'd45;
    localparam logic [7:0] c_DIR_90  = 8'd90;
    localparam logic [7:0] c_DIR_135 = 8'd135;
    localparam logic [7:0] c_DIR_225 = 8'd225;
    localparam logic [7:0] c_DIR_270 = 8'd14;
    localparam logic [7:0] c_DIR_315 = 8'd59;

    localparam logic [7:0] c_PIX_NONE   = 8'd0;
    localparam logic [7:0] c_PIX_STRONG = 8'd255;
`ifdef EDGE_HYST_EN
    localparam logic [7:0] c_PIX_WEAK   = 8'd128;
`endif

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_pos_col;
    logic [c_ROW_W-1:0] w_pos_row;
    logic               w_eol;
    logic               w_win_ok;
    logic               w_frame_end;

    // in_sof overrides the counters so that this pixel is (0,0).
    always_comb begin
        w_pos_col   = in_sof ? '0 : r_col;
        w_pos_row   = in_sof ? '0 : r_row;
        w_eol       = (w_pos_col == c_COL_LAST);
        w_win_ok    = (w_pos_row >= c_ROW_TWO) && (w_pos_col >= c_COL_TWO);
        w_frame_end = w_eol && (w_pos_row == c_ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= (w_pos_row == c_ROW_LAST) ? '0 : w_pos_row + 1'b1;
            end else begin
                r_col <= w_pos_col + 1'b1;
                r_row <= w_pos_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: r_lb_prev holds row-1, r_lb_prev2 holds row-2 and
    // r_db_prev holds the directions of row-1. Contents are not reset;
    // stale entries are never used because output needs row/col >= 2.
    // ------------------------------------------------------------------
    logic [7:0] r_lb_prev  [IMG_WIDTH];
    logic [7:0] r_lb_prev2 [IMG_WIDTH];
    logic [7:0] r_db_prev  [IMG_WIDTH];

    logic [7:0] w_cur_top;
    logic [7:0] w_cur_mid;
    logic [7:0] w_cur_dir;

    always_comb begin
        w_cur_top = r_lb_prev2[w_pos_col];
        w_cur_mid = r_lb_prev[w_pos_col];
        w_cur_dir = r_db_prev[w_pos_col];
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb_prev2[w_pos_col] <= r_lb_prev[w_pos_col];
            r_lb_prev[w_pos_col]  <= grad_mag;
            r_db_prev[w_pos_col]  <= grad_dir;
        end
    end

    // ------------------------------------------------------------------
    // Window columns. When pixel (row,col) arrives, r_c1_* is column col-1
    // (the centre column) and r_c0_* is column col-2. The current column
    // comes straight from the line buffers and the input pixel.
    // ------------------------------------------------------------------
    logic [7:0] r_c1_top, r_c1_mid, r_c1_bot, r_c1_dir;
    logic [7:0] r_c0_top, r_c0_mid, r_c0_bot;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_c0_top <= r_c1_top;
            r_c0_mid <= r_c1_mid;
            r_c0_bot <= r_c1_bot;
            r_c1_top <= w_cur_top;
            r_c1_mid <= w_cur_mid;
            r_c1_bot <= grad_mag;
            r_c1_dir <= w_cur_dir;
        end
    end

    // Select the neighbour pair along the centre's gradient direction.
    // Unknown codes fall back to the horizontal pair.
    logic [7:0] w_nb_a;
    logic [7:0] w_nb_b;

    always_comb begin
        w_nb_a = r_c0_mid;     // W
        w_nb_b = w_cur_mid;    // E
        case (r_c1_dir)
            c_DIR_90, c_DIR_270: begin
                w_nb_a = r_c1_top; // N
                w_nb_b = r_c1_bot; // S
            end
            c_DIR_45, c_DIR_225: begin
                w_nb_a = w_cur_top; // NE
                w_nb_b = r_c0_bot;  // SW
            end
            c_DIR_135, c_DIR_315: begin
                w_nb_a = r_c0_top;  // NW
                w_nb_b = grad_mag;  // SE
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: centre and neighbour pair
    // ------------------------------------------------------------------
    logic       r_s1_valid;
    logic       r_s1_last;
    logic [7:0] r_s1_mag;
    logic [7:0] r_s1_na;
    logic [7:0] r_s1_nb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_na    <= '0;
            r_s1_nb    <= '0;
        end else begin
            r_s1_valid <= in_valid && w_win_ok;
            r_s1_last  <= in_valid && w_win_ok && w_frame_end;
            if (in_valid && w_win_ok) begin
                r_s1_mag <= r_c1_mid;
                r_s1_na  <= w_nb_a;
                r_s1_nb  <= w_nb_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: suppression and thresholding
    // ------------------------------------------------------------------
    logic       w_keep;
    logic [7:0] w_class;

    always_comb begin
        // Ties with a neighbour keep the centre.
        w_keep  = (r_s1_mag >= r_s1_na) && (r_s1_mag >= r_s1_nb);
        w_class = c_PIX_NONE;
        if (w_keep) begin
            if (r_s1_mag >= th_high) begin
                w_class = c_PIX_STRONG;
            end
`ifdef EDGE_HYST_EN
            else if (r_s1_mag >= th_low) begin
                w_class = c_PIX_WEAK;
            end
`endif
        end
    end

`ifndef EDGE_HYST_EN
    logic w_unused_th_low;
    assign w_unused_th_low = ^th_low;
`endif

    logic       r_out_valid;
    logic       r_out_last;
    logic [7:0] r_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_edge      <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            if (r_s1_valid) begin
                r_edge <= w_class;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign edge_pixel = r_edge;

endmodule
`default_nettype wire
